// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: stall/flush/redirect generation, mul/div wait,
// data-memory timeout error and saturating stall/flush performance counters.
module pipeline_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             ex_md_start,
  input  logic             md_done,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             stall_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             pc_redirect,
  output logic [1:0]       ctrl_state,
  output logic             ctrl_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_ERR     = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             md_done_q, md_done_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic mem_stall, load_use, branch, md_fin;

  assign mem_stall = mem_req & ~dmem_ready;
  assign branch    = ex_valid & ex_branch_taken;
  assign md_fin    = md_done | md_done_q;
  assign load_use  = ex_valid & ex_mem_read & (ex_rd_addr != 5'd0) &
                     ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
                      (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));

  // Priority: ERR > mem_stall > MD_WAIT > branch > load-use > normal.
  always_comb begin
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    stall_mem_wb = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    pc_redirect  = 1'b0;
    if (state_q == ST_ERR || mem_stall) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
      stall_mem_wb = 1'b1;
    end else if (state_q == ST_MD_WAIT) begin
      // On the completion cycle nothing is held so the md result leaves EX.
      if (!md_fin) begin
        stall_pc     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
      end
    end else if (branch) begin
      pc_redirect = 1'b1;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (load_use) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q != ST_ERR) begin
      if (mem_stall && wait_cnt_q == TIMEOUT_LAST)
        state_d = ST_ERR;
      else if (state_q == ST_RUN && ex_valid && ex_md_start && !mem_stall && !md_done)
        state_d = ST_MD_WAIT;
      else if (state_q == ST_MD_WAIT && !mem_stall && md_fin)
        state_d = ST_RUN;
    end
    // Remember a completion that landed while memory froze the pipe.
    md_done_d   = (state_q == ST_MD_WAIT) & mem_stall & md_fin;
    wait_cnt_d  = mem_stall ? ((wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1) : 8'd0;
    error_d     = error_q | (state_d == ST_ERR);
    stall_cnt_d = (stall_pc && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (pc_redirect && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      md_done_q   <= 1'b0;
      error_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      md_done_q   <= md_done_d;
      error_q     <= error_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ctrl_state = state_q;
  assign ctrl_error = error_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios plus randomized traffic
// compared every cycle against a priority-rule reference model.
module tb_pipeline_ctrl;
  localparam int     TMO  = 4;
  localparam int     CW   = 8;
  localparam longint CMAX = (longint'(1) << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] id_rs1_addr = '0, id_rs2_addr = '0, ex_rd_addr = '0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_valid = 0, ex_mem_read = 0;
  logic ex_branch_taken = 0, ex_md_start = 0, md_done = 0, mem_req = 0, dmem_ready = 0;
  logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect, ctrl_error;
  logic [1:0] ctrl_state;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start), .md_done(md_done),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .stall_mem_wb(stall_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .pc_redirect(pc_redirect), .ctrl_state(ctrl_state), .ctrl_error(ctrl_error),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: 0 RUN, 1 MD_WAIT, 2 ERR; counters as plain integers.
  int     m_state = 0, m_wait = 0;
  bit     m_pend = 0;
  longint m_scnt = 0, m_fcnt = 0;

  // Output vector: {stall pc,ifid,idex,exmem,memwb, flush ifid,idex,exmem, redirect}
  function automatic logic [8:0] model_outs();
    bit ms, lu;
    logic [8:0] o;
    ms = mem_req && !dmem_ready;
    lu = ex_valid && ex_mem_read && ex_rd_addr != 0 &&
         ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
    o = '0;
    if (m_state == 2 || ms)                o = 9'b111110000;
    else if (m_state == 1) begin
      if (!(md_done || m_pend))            o = 9'b111000010;
    end
    else if (ex_valid && ex_branch_taken)  o = 9'b000001101;
    else if (lu)                           o = 9'b110000100;
    return o;
  endfunction

  function automatic logic [8:0] dut_outs();
    return {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
            flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect};
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".outs"},  longint'(dut_outs()), longint'(model_outs()));
    chk({tag, ".state"}, longint'(ctrl_state), longint'(m_state));
    chk({tag, ".error"}, longint'(ctrl_error), longint'(m_state == 2));
    chk({tag, ".scnt"},  longint'(stall_cnt),  m_scnt);
    chk({tag, ".fcnt"},  longint'(flush_cnt),  m_fcnt);
  endtask

  // Inputs are already applied; check mid-cycle, then advance the model at the edge.
  task automatic step(input string tag);
    logic [8:0] o;
    bit ms;
    int n_state, n_wait;
    bit n_pend;
    longint n_scnt, n_fcnt;
    @(negedge clk);
    check_all(tag);
    o  = model_outs();
    ms = mem_req && !dmem_ready;
    n_state = m_state;
    if (m_state != 2) begin
      if (ms && m_wait == TMO - 1)                                              n_state = 2;
      else if (m_state == 0 && ex_valid && ex_md_start && !ms && !md_done)      n_state = 1;
      else if (m_state == 1 && !ms && (md_done || m_pend))                      n_state = 0;
    end
    n_pend = (m_state == 1) && ms && (md_done || m_pend);
    n_wait = ms ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
    n_scnt = (o[8] && m_scnt < CMAX) ? m_scnt + 1 : m_scnt;
    n_fcnt = (o[0] && m_fcnt < CMAX) ? m_fcnt + 1 : m_fcnt;
    @(posedge clk);
    #1;
    m_state = n_state; m_wait = n_wait; m_pend = n_pend; m_scnt = n_scnt; m_fcnt = n_fcnt;
  endtask

  task automatic clear_in();
    id_rs1_addr = 0; id_rs2_addr = 0; ex_rd_addr = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_valid = 0; ex_mem_read = 0;
    ex_branch_taken = 0; ex_md_start = 0; md_done = 0; mem_req = 0; dmem_ready = 0;
  endtask

  // Reset must take effect without any clock edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    m_state = 0; m_wait = 0; m_pend = 0; m_scnt = 0; m_fcnt = 0;
    check_all(tag);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_valid = 1; ex_mem_read = 1; ex_rd_addr = rd; id_uses_rs1 = 1; id_rs1_addr = 5;
  endtask

  initial begin
    clear_in();
    do_reset("rst0");

    // Load-use hazard, then same with x0 destination.
    set_load_use(5);
    repeat (3) step("lu");
    chk("lu_scnt3", longint'(stall_cnt), 3);
    set_load_use(0);
    repeat (2) step("lu_x0");

    // Branch overrides load-use.
    set_load_use(5); ex_branch_taken = 1;
    step("br_lu");
    chk("br_fcnt", longint'(flush_cnt), 1);
    clear_in();

    // Multi-cycle op: start, done five cycles later.
    do_reset("rst_md");
    ex_valid = 1; ex_md_start = 1;
    step("md_start");
    clear_in();
    repeat (4) step("md_wait");
    md_done = 1;
    step("md_done");
    md_done = 0;
    step("md_after");
    chk("md_state_run", longint'(ctrl_state), 0);

    // Completion during memory stall inside MD_WAIT.
    ex_valid = 1; ex_md_start = 1;
    step("md2_start");
    clear_in();
    step("md2_wait");
    mem_req = 1; dmem_ready = 0;
    step("md2_ms1");
    md_done = 1;
    step("md2_ms2");
    md_done = 0;
    step("md2_ms3");
    dmem_ready = 1;
    step("md2_rel");
    clear_in();
    chk("md2_exit", longint'(ctrl_state), 0);
    step("md2_idle");

    // Async reset in the middle of MD_WAIT.
    ex_valid = 1; ex_md_start = 1;
    step("md3_start");
    clear_in();
    step("md3_wait");
    chk("md3_in_wait", longint'(ctrl_state), 1);
    do_reset("rst_mid_md");

    // Memory timeout into sticky ERR.
    mem_req = 1; dmem_ready = 0;
    repeat (5) step("tmo");
    chk("tmo_state", longint'(ctrl_state), 2);
    clear_in();
    ex_valid = 1; ex_branch_taken = 1;
    repeat (3) step("err_sticky");
    clear_in();
    do_reset("rst_err");
    step("post_err");

    // Stall counter saturation.
    set_load_use(5);
    repeat (CMAX + 5) step("sat");
    chk("sat_scnt", longint'(stall_cnt), CMAX);
    clear_in();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset("rst_rand");
      id_rs1_addr     = 5'($urandom_range(0, 3));
      id_rs2_addr     = 5'($urandom_range(0, 3));
      ex_rd_addr      = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      ex_valid        = ($urandom_range(0, 3) != 0);
      ex_mem_read     = ($urandom_range(0, 2) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      ex_md_start     = ($urandom_range(0, 7) == 0);
      md_done         = ($urandom_range(0, 5) == 0);
      mem_req         = 1'($urandom_range(0, 1));
      dmem_ready      = ($urandom_range(0, 2) != 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
